mac_accumulator: RTL

- Sequential stage directly downstream of the signed 8x8 combinational multiplier.
- Consumes its 16-bit two's-complement product one term per handshake and accumulates a programmed number of terms into a wide saturating accumulator.
- Presents the final dot-product result on a valid/ready output port.
- Lets the multiplier datapath compute multi-term sums, e.g. FIR taps or vector dot products.

---
 rtl/mac_accumulator_pkg.sv | 14 +
 rtl/mac_accumulator_sat_adder.sv | 21 ++
 rtl/mac_accumulator.sv | 70 +++++++
 3 files changed

// File: rtl/mac_accumulator_pkg.sv
// mac_accumulator_pkg: state encodings and saturation limit formulas for the MAC accumulator
package mac_accumulator_pkg;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    function automatic logic [63:0] acc_max_f(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] acc_min_f(input int w);
        return 64'd1 << (w - 1);
    endfunction
endpackage

// File: rtl/mac_accumulator_sat_adder.sv
// sat_adder: signed ACC_W-bit add, clamped to the representable range with an overflow flag
module sat_adder
    import mac_accumulator_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);
    localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(acc_max_f(ACC_W));
    localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(acc_min_f(ACC_W));

    logic [ACC_W:0] w_sum;

    assign w_sum = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    // Top two bits disagree exactly when the true sum left the ACC_W range; bit ACC_W holds its sign.
    assign ovf   = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    assign sum   = !ovf ? w_sum[ACC_W-1:0] : (w_sum[ACC_W] ? ACC_MIN : ACC_MAX);
endmodule

// File: rtl/mac_accumulator.sv
// mac_accumulator: accumulates n_terms signed products into a saturating sum, presented on a valid/ready port
module mac_accumulator
    import mac_accumulator_pkg::*;
#(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  n_terms,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              overflow,
    output logic              busy
);
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_remaining;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [ACC_W-1:0] w_prod_ext;
    logic [ACC_W-1:0] w_sum;
    logic             w_ovf;

    assign w_prod_ext = {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};

    sat_adder #(.ACC_W(ACC_W)) u_sat_adder (
        .a   (r_acc),
        .b   (w_prod_ext),
        .sum (w_sum),
        .ovf (w_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_acc       <= '0;
                    r_ovf       <= 1'b0;
                    r_remaining <= n_terms;
                    r_state     <= (n_terms == '0) ? S_HOLD : S_ACCUM;
                end
                S_ACCUM: if (in_valid) begin
                    r_acc       <= w_sum;
                    r_ovf       <= r_ovf | w_ovf;
                    r_remaining <= r_remaining - 1'b1;
                    if (r_remaining == CNT_W'(1)) r_state <= S_HOLD;
                end
                S_HOLD: if (out_ready) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_ACCUM);
    assign out_valid = (r_state == S_HOLD);
    assign busy      = in_ready | out_valid;
    assign acc_out   = r_acc;
    assign overflow  = r_ovf;
endmodule
